// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write/read controllers:
// depth derivation and Gray/binary pointer conversions.
package fifo_pkg;

  // Pointer helpers operate on a zero-extended word of this width.
  localparam int PTR_MAX_W = 32;

  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Zero-extended input keeps the upper prefix at 0, so any width up to PTR_MAX_W works.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage flop synchronizer for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_reg;
  logic [WIDTH-1:0] q2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_reg <= '0;
      q2_reg <= '0;
    end else begin
      q1_reg <= d;
      q2_reg <= q1_reg;
    end
  end

  assign q = q2_reg;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: write pointer, memory write strobe,
// and conservative full / almost-full / level / overflow flags.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4,
  parameter int AF_LEVEL  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_ptr_gray,
  input  logic                 overflow_clr,
  output logic                 mem_en,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic [ADDR_SIZE:0]   wr_ptr_gray,
  output logic                 wr_full,
  output logic                 wr_almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = depth_of(ADDR_SIZE);

  // Parameter sanity: elaborates to nothing, present only to bound the legal space.
  if (DATA_SIZE < 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || ADDR_SIZE < 2) begin : g_illegal_params
  end

  logic [PW-1:0] wptr_bin_reg, wptr_bin_next;
  logic [PW-1:0] wgray_reg, wgray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_reg, level_next;
  logic          full_reg, full_next;
  logic          af_reg, af_next;
  logic          overflow_reg, overflow_next;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rq2)
  );

  always_comb begin
    // Held low during reset so a write in flight at reset assertion is dropped.
    mem_en        = wr_en & ~full_reg & ~rst;
    wptr_bin_next = wptr_bin_reg + PW'(mem_en);
    wgray_next    = PW'(bin2gray(PTR_MAX_W'(wptr_bin_next)));
    rbin          = PW'(gray2bin(PTR_MAX_W'(rq2)));
    full_next     = (wgray_next == {~rq2[PW-1 -: 2], rq2[PW-3:0]});
    level_next    = wptr_bin_next - rbin;
    af_next       = (level_next >= PW'(AF_LEVEL));
    overflow_next = (wr_en & full_reg) | (overflow_reg & ~overflow_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_bin_reg <= '0;
      wgray_reg    <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      af_reg       <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wptr_bin_reg <= wptr_bin_next;
      wgray_reg    <= wgray_next;
      level_reg    <= level_next;
      full_reg     <= full_next;
      af_reg       <= af_next;
      overflow_reg <= overflow_next;
    end
  end

  assign wr_addr        = wptr_bin_reg[ADDR_SIZE-1:0];
  assign wr_ptr_gray    = wgray_reg;
  assign wr_full        = full_reg;
  assign wr_almost_full = af_reg;
  assign wr_level       = level_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl against a counter-based occupancy model.
module tb_fifo_wr_ctrl;

  localparam int ADDR_SIZE = 4;
  localparam int DEPTH     = 16;
  localparam int AF_LEVEL  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 wr_en;
  logic [ADDR_SIZE:0]   rd_ptr_gray;
  logic                 overflow_clr;
  logic                 mem_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE:0]   wr_ptr_gray;
  logic                 wr_full;
  logic                 wr_almost_full;
  logic [ADDR_SIZE:0]   wr_level;
  logic                 overflow;

  fifo_wr_ctrl #(.DATA_SIZE(8), .ADDR_SIZE(ADDR_SIZE), .AF_LEVEL(AF_LEVEL)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .rd_ptr_gray    (rd_ptr_gray),
    .overflow_clr   (overflow_clr),
    .mem_en         (mem_en),
    .wr_addr        (wr_addr),
    .wr_ptr_gray    (wr_ptr_gray),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: write count and read count mod 2*DEPTH; reads seen 2 edges late.
  logic [4:0] m_wptr, m_r1, m_r2, m_level, prev_gray;
  bit         m_full, m_af, m_ovf, m_acc, wrapped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wptr = '0; m_r1 = '0; m_r2 = '0; m_level = '0; prev_gray = '0;
    m_full = 0; m_af = 0; m_ovf = 0; m_acc = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_gray"}, wr_ptr_gray, 0);
    check({tag, "_full"}, wr_full, 0);
    check({tag, "_af"}, wr_almost_full, 0);
    check({tag, "_level"}, wr_level, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  // One clock: drive at negedge, check comb outputs, then registered outputs after posedge.
  task automatic step(input bit we, input logic [4:0] rp, input bit clr);
    logic [4:0] wnew;
    @(negedge clk);
    wr_en        = we;
    rd_ptr_gray  = rp ^ (rp >> 1);
    overflow_clr = clr;
    #1;
    m_acc = we && !m_full;
    check("mem_en", mem_en, m_acc);
    check("wr_addr", wr_addr, m_wptr[3:0]);
    @(posedge clk);
    #1;
    m_ovf   = (we && m_full) || (m_ovf && !clr);
    wnew    = m_wptr + 5'(m_acc);
    m_level = wnew - m_r2;
    m_full  = (m_level == 5'(DEPTH));
    m_af    = (m_level >= 5'(AF_LEVEL));
    m_r2    = m_r1;
    m_r1    = rp;
    if (m_wptr == 5'd31 && wnew == 5'd0) wrapped = 1;
    m_wptr  = wnew;
    check("wr_full", wr_full, m_full);
    check("wr_almost_full", wr_almost_full, m_af);
    check("wr_level", wr_level, m_level);
    check("overflow", overflow, m_ovf);
    check("wr_ptr_gray", wr_ptr_gray, wnew ^ (wnew >> 1));
    check("gray_one_bit", $countones(wr_ptr_gray ^ prev_gray), m_acc ? 1 : 0);
    prev_gray = wr_ptr_gray;
    $display("step we=%0d rp=%0d clr=%0d acc=%0d addr=%0d gray=%b lvl=%0d full=%0d af=%0d ovf=%0d",
             we, rp, clr, m_acc, wr_addr, wr_ptr_gray, wr_level, wr_full, wr_almost_full, overflow);
  endtask

  initial begin
    logic [4:0] rcur;
    int accepted;

    // Power-on reset
    rst = 1'b1; wr_en = 1'b0; rd_ptr_gray = '0; overflow_clr = 1'b0;
    wrapped = 0;
    model_reset();
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_addr", wr_addr, 0);
    check("post_rst_full", wr_full, 0);

    // Fill to full with the read side idle
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_addr", wr_addr, i);
      step(1, 5'd0, 0);
      check("fill_af", wr_almost_full, (i >= AF_LEVEL - 1) ? 1 : 0);
      check("fill_full", wr_full, (i == DEPTH - 1) ? 1 : 0);
    end
    check("full_level", wr_level, 16);
    check("full_gray", wr_ptr_gray, 5'b11000);

    // Writes while full are rejected and set sticky overflow
    step(1, 5'd0, 0);
    step(1, 5'd0, 0);
    check("ovf_addr", wr_addr, 0);
    check("ovf_set", overflow, 1);
    step(0, 5'd0, 0);
    check("ovf_sticky", overflow, 1);
    step(0, 5'd0, 1);
    check("ovf_clr", overflow, 0);
    step(1, 5'd0, 1);
    check("ovf_set_wins", overflow, 1);

    // One read releases space exactly 3 clocks after the Gray change
    step(0, 5'd1, 0);
    check("rel_full_1", wr_full, 1);
    step(0, 5'd1, 0);
    check("rel_full_2", wr_full, 1);
    step(0, 5'd1, 0);
    check("rel_full_3", wr_full, 0);
    check("rel_level_3", wr_level, 15);
    check("rel_addr", wr_addr, 0);
    step(1, 5'd1, 0);
    check("rel_write_level", wr_level, 16);

    // Randomized writes with legal read-pointer advances, through the 31->0 rollover
    rcur = 5'd1;
    accepted = 0;
    for (int i = 0; i < 400 && accepted < 40; i++) begin
      if (rcur != m_wptr && $urandom_range(0, 1) == 1) rcur = rcur + 5'd1;
      step($urandom_range(0, 3) != 0, rcur, 0);
      if (m_acc) accepted++;
    end
    check("wrap_count", accepted, 40);
    check("wrap_seen", wrapped, 1);

    // Mid-cycle reset with a write pending
    @(negedge clk);
    wr_en = 1'b1; rd_ptr_gray = '0; overflow_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    model_reset();
    #1;
    check("mid_rst_addr", wr_addr, 0);

    // Almost-full boundary at level 13 -> 14 and back
    for (int i = 0; i < AF_LEVEL - 1; i++) step(1, 5'd0, 0);
    repeat (3) step(0, 5'd0, 0);
    check("af_at13_level", wr_level, 13);
    check("af_at13", wr_almost_full, 0);
    step(1, 5'd0, 0);
    check("af_at14", wr_almost_full, 1);
    step(0, 5'd1, 0);
    check("af_rel_1", wr_almost_full, 1);
    step(0, 5'd1, 0);
    check("af_rel_2", wr_almost_full, 1);
    step(0, 5'd1, 0);
    check("af_rel_3", wr_almost_full, 0);
    check("af_rel_level", wr_level, 13);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
